// File: rtl/vanilla_remote_req_responder.sv
// Memory-side responder for vanilla-core remote requests: stores, loads and
// read-modify-write AMOs against a 1-cycle-latency word SRAM, loads/AMOs answered over valid/yumi.
package vanilla_remote_pkg;
  localparam int RV32_reg_data_width_gp = 32;

  typedef enum logic [1:0] {
    e_amo_swap = 2'b00,
    e_amo_or   = 2'b01,
    e_amo_add  = 2'b10,
    e_amo_rsvd = 2'b11
  } amo_type_e;

  typedef struct packed {
    logic       float_wb;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  typedef struct packed {
    logic        write_not_read;
    logic        is_amo_op;
    amo_type_e   amo_type;
    logic [3:0]  mask;
    load_info_s  load_info;
    logic [4:0]  reg_id;
    logic [31:0] data;
    logic [31:0] addr;
  } remote_req_s;

  typedef struct packed {
    logic        float_wb;
    logic        is_unsigned_op;
    logic        is_byte_op;
    logic        is_hex_op;
    logic [1:0]  part_sel;
    logic [4:0]  reg_id;
    logic [31:0] data;
  } remote_load_resp_s;
endpackage

module vanilla_remote_req_responder
  import vanilla_remote_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_v_i,
  input  remote_req_s             req_i,
  output logic                    req_ready_o,
  output logic                    mem_v_o,
  output logic                    mem_w_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  output logic [data_width_p-1:0] mem_data_o,
  output logic [3:0]              mem_mask_o,
  input  logic [data_width_p-1:0] mem_data_i,
  output logic                    resp_v_o,
  output remote_load_resp_s       resp_o,
  input  logic                    resp_yumi_i,
  output logic                    err_o
);

  if (data_width_p != RV32_reg_data_width_gp) begin : g_bad_width
    $error("vanilla_remote_req_responder: data_width_p must be 32");
  end

  typedef enum logic [1:0] {IDLE, LD_RD, AMO_RD, RESP} state_e;

  state_e                  state_r, state_n;
  logic [addr_width_p-1:0] addr_r;
  logic                    in_range_r;
  amo_type_e               amo_type_r;
  logic [data_width_p-1:0] amo_data_r;
  logic [4:0]              reg_id_r;
  load_info_s              load_info_r;
  logic [data_width_p-1:0] resp_data_r;
  logic [data_width_p-1:0] amo_new;

  logic req_in_range, is_store, capture;

  assign req_in_range = ((req_i.addr >> (addr_width_p + 2)) == 32'd0) && (req_i.addr[1:0] == 2'b00);
  assign is_store     = req_i.write_not_read & ~req_i.is_amo_op;
  // Loads and AMOs latch their context at acceptance; req_i is free to change afterwards.
  assign capture      = (state_r == IDLE) && req_v_i && !is_store;

  always_comb begin
    amo_new = amo_data_r;
    case (amo_type_r)
      e_amo_or:  amo_new = mem_data_i | amo_data_r;
      e_amo_add: amo_new = mem_data_i + amo_data_r;
      default:   amo_new = amo_data_r;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_n     = state_r;
    req_ready_o = 1'b0;
    mem_v_o     = 1'b0;
    mem_w_o     = 1'b0;
    mem_addr_o  = req_i.addr[addr_width_p+1:2];
    mem_data_o  = req_i.data;
    mem_mask_o  = req_i.mask;
    resp_v_o    = 1'b0;
    err_o       = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_v_i) begin
          err_o   = ~req_in_range;
          mem_v_o = req_in_range;
          mem_w_o = is_store;
          if (!is_store) state_n = req_i.is_amo_op ? AMO_RD : LD_RD;
        end
      end
      LD_RD: state_n = RESP;
      AMO_RD: begin
        mem_addr_o = addr_r;
        mem_data_o = amo_new;
        mem_mask_o = 4'hF;
        mem_w_o    = 1'b1;
        mem_v_o    = in_range_r && (amo_type_r != e_amo_rsvd);
        state_n    = RESP;
      end
      RESP: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset overrides everything, including a pending AMO write.
    if (reset_i) begin
      state_n     = IDLE;
      req_ready_o = 1'b0;
      mem_v_o     = 1'b0;
      resp_v_o    = 1'b0;
      err_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      // NOTE: datapath registers are reset too, so resp_o reads 0 out of reset.
      state_r     <= IDLE;
      addr_r      <= '0;
      in_range_r  <= 1'b0;
      amo_type_r  <= e_amo_swap;
      amo_data_r  <= '0;
      reg_id_r    <= '0;
      load_info_r <= '0;
      resp_data_r <= '0;
    end else begin
      state_r <= state_n;
      if (capture) begin
        addr_r      <= req_i.addr[addr_width_p+1:2];
        in_range_r  <= req_in_range;
        amo_type_r  <= req_i.amo_type;
        amo_data_r  <= req_i.data;
        reg_id_r    <= req_i.reg_id;
        load_info_r <= req_i.load_info;
      end
      // Out-of-range reads never touched the SRAM, so their response is forced to zero.
      if (state_r == LD_RD || state_r == AMO_RD)
        resp_data_r <= in_range_r ? mem_data_i : '0;
    end
  end

  always_comb begin
    resp_o                = '0;
    resp_o.float_wb       = load_info_r.float_wb;
    resp_o.is_unsigned_op = load_info_r.is_unsigned_op;
    resp_o.is_byte_op     = load_info_r.is_byte_op;
    resp_o.is_hex_op      = load_info_r.is_hex_op;
    resp_o.part_sel       = load_info_r.part_sel;
    resp_o.reg_id         = reg_id_r;
    resp_o.data           = resp_data_r;
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) resp_yumi_i |-> resp_v_o);

endmodule

// File: tb/tb_vanilla_remote_req_responder.sv
// Self-checking bench: directed scenarios plus random ops, checked against a word-array memory model.
module tb_vanilla_remote_req_responder;
  import vanilla_remote_pkg::*;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              req_v_i;
  remote_req_s       req_i;
  logic              req_ready_o;
  logic              mem_v_o, mem_w_o;
  logic [AW-1:0]     mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [3:0]        mem_mask_o;
  logic [31:0]       mem_data_i;
  logic              resp_v_o;
  remote_load_resp_s resp_o;
  logic              resp_yumi_i;
  logic              err_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sram  [WORDS];
  logic [31:0] model [WORDS];

  always #5 clk = ~clk;

  vanilla_remote_req_responder #(.addr_width_p(AW), .data_width_p(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_i(req_i), .req_ready_o(req_ready_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i), .resp_v_o(resp_v_o), .resp_o(resp_o),
    .resp_yumi_i(resp_yumi_i), .err_o(err_o)
  );

  // Environment SRAM: byte-masked write, 1-cycle read.
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else begin
        mem_data_i <= sram[mem_addr_o];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a < (32'd1 << (AW + 2))) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] amo_calc(input amo_type_e t, input logic [31:0] old, input logic [31:0] d);
    case (t)
      e_amo_swap: return d;
      e_amo_or:   return old | d;
      e_amo_add:  return old + d;
      default:    return old;
    endcase
  endfunction

  function automatic remote_req_s mk_req(input logic wnr, input logic amo, input amo_type_e t,
                                         input logic [3:0] m, input load_info_s li, input logic [4:0] rid,
                                         input logic [31:0] d, input logic [31:0] a);
    remote_req_s r;
    r.write_not_read = wnr; r.is_amo_op = amo; r.amo_type = t; r.mask = m;
    r.load_info = li; r.reg_id = rid; r.data = d; r.addr = a;
    return r;
  endfunction

  task automatic scramble_req();
    logic [95:0] junk = {$urandom, $urandom, $urandom};
    req_i = remote_req_s'(junk[$bits(remote_req_s)-1:0]);
  endtask

  task automatic wait_ready();
    int i = 0;
    while (!req_ready_o && i < 20) begin
      @(posedge clk); #1; i++;
    end
    check("ready_wait", req_ready_o, 1'b1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic ok = addr_ok(a);
    wait_ready();
    req_i = mk_req(1'b1, 1'b0, e_amo_swap, m, '0, 5'd0, d, a);
    req_v_i = 1'b1;
    #1;
    check("st_v_err", {mem_v_o, err_o}, {ok, ~ok});
    if (ok) check("st_bus", {mem_w_o, mem_addr_o, mem_data_o, mem_mask_o}, {1'b1, a[AW+1:2], d, m});
    @(posedge clk); #1;
    req_v_i = 1'b0;
    scramble_req();
    if (ok) model[a / 4] = merge(model[a / 4], d, m);
  endtask

  task automatic do_rd(input logic is_amo, input amo_type_e t, input logic [31:0] a, input logic [31:0] d,
                       input load_info_s li, input logic [4:0] rid, input int hold, output logic [31:0] got);
    logic              ok = addr_ok(a);
    logic [31:0]       old;
    logic [31:0]       nv;
    logic              wr;
    remote_load_resp_s exp;
    old = ok ? model[a / 4] : 32'd0;
    nv  = amo_calc(t, old, d);
    wr  = is_amo && ok && (t != e_amo_rsvd);
    exp = '{float_wb: li.float_wb, is_unsigned_op: li.is_unsigned_op, is_byte_op: li.is_byte_op,
            is_hex_op: li.is_hex_op, part_sel: li.part_sel, reg_id: rid, data: old};
    wait_ready();
    req_i = mk_req(is_amo, is_amo, t, 4'($urandom), li, rid, d, a);
    req_v_i = 1'b1;
    #1;
    check("rd_acc", {mem_v_o, mem_w_o, err_o}, {ok, 1'b0, ~ok});
    if (ok) check("rd_addr", mem_addr_o, a[AW+1:2]);
    @(posedge clk); #1;
    req_v_i = 1'b0;
    scramble_req();
    check("rd_wait_v", resp_v_o, 1'b0);
    if (is_amo) begin
      check("amo_wr_v", mem_v_o, wr);
      if (wr) check("amo_wr_bus", {mem_w_o, mem_addr_o, mem_data_o, mem_mask_o}, {1'b1, a[AW+1:2], nv, 4'hF});
    end else begin
      check("ld_idle_mem", mem_v_o, 1'b0);
    end
    if (wr) model[a / 4] = nv;
    @(posedge clk); #1;
    check("resp_v", resp_v_o, 1'b1);
    check("resp", resp_o, exp);
    got = resp_o.data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_v_ready", {resp_v_o, req_ready_o}, 2'b10);
      check("hold_resp", resp_o, exp);
    end
    resp_yumi_i = 1'b1;
    req_v_i = 1'b1;
    #1;
    check("yumi_no_accept", req_ready_o, 1'b0);
    @(posedge clk); #1;
    resp_yumi_i = 1'b0;
    req_v_i = 1'b0;
    check("after_yumi", {resp_v_o, req_ready_o}, 2'b01);
  endtask

  initial begin
    logic [31:0] got;
    load_info_s  li0, li_bp;
    li0   = '0;
    li_bp = '{float_wb: 1'b1, is_unsigned_op: 1'b0, is_byte_op: 1'b1, is_hex_op: 1'b0, part_sel: 2'b10};
    for (int i = 0; i < WORDS; i++) begin
      sram[i]  = 32'd0;
      model[i] = 32'd0;
    end
    mem_data_i  = 32'd0;
    resp_yumi_i = 1'b0;
    reset_i     = 1'b1;
    req_v_i     = 1'b1;
    req_i       = mk_req(1'b1, 1'b0, e_amo_swap, 4'hF, li0, 5'd0, 32'h1234_5678, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {req_ready_o, resp_v_o, mem_v_o, err_o}, 4'b0000);
    check("rst_resp", resp_o, 43'd0);
    req_v_i = 1'b0;
    reset_i = 1'b0;
    #1;
    check("rst_release_ready", req_ready_o, 1'b1);

    // Store then load
    do_store(32'h10, 32'hDEAD_BEEF, 4'hF);
    do_rd(1'b0, e_amo_swap, 32'h10, 32'h0, li0, 5'd5, 0, got);
    check("tp_store_load", got, 32'hDEAD_BEEF);

    // Byte-masked store
    do_store(32'h8, 32'h1122_3344, 4'hF);
    do_store(32'h8, 32'hAA00_BB00, 4'b1010);
    do_rd(1'b0, e_amo_swap, 32'h8, 32'h0, li0, 5'd1, 0, got);
    check("tp_masked", got, 32'hAA22_BB44);

    // AMO add wraps
    do_store(32'hC, 32'hFFFF_FFFF, 4'hF);
    do_rd(1'b1, e_amo_add, 32'hC, 32'd2, li0, 5'd2, 0, got);
    check("tp_amoadd_old", got, 32'hFFFF_FFFF);
    do_rd(1'b0, e_amo_swap, 32'hC, 32'h0, li0, 5'd2, 0, got);
    check("tp_amoadd_new", got, 32'h1);

    // AMO or / swap / reserved
    do_store(32'h0, 32'h0F, 4'hF);
    do_rd(1'b1, e_amo_or, 32'h0, 32'hF0, li0, 5'd3, 1, got);
    check("tp_amoor_old", got, 32'h0F);
    do_rd(1'b1, e_amo_swap, 32'h0, 32'h7, li0, 5'd3, 0, got);
    check("tp_amoswap_old", got, 32'hFF);
    do_rd(1'b1, e_amo_rsvd, 32'h0, 32'h55, li0, 5'd3, 0, got);
    check("tp_rsvd_old", got, 32'h7);
    do_rd(1'b0, e_amo_swap, 32'h0, 32'h0, li0, 5'd3, 0, got);
    check("tp_rsvd_kept", got, 32'h7);

    // Backpressure with load_info echo
    do_rd(1'b0, e_amo_swap, 32'h10, 32'h0, li_bp, 5'd9, 5, got);

    // Out of range: high address, misaligned, store and AMO
    do_rd(1'b0, e_amo_swap, 32'h1 << (AW + 2), 32'h0, li0, 5'd4, 0, got);
    check("tp_oor_data", got, 32'h0);
    do_rd(1'b0, e_amo_swap, 32'h11, 32'h0, li0, 5'd4, 0, got);
    do_store(32'h8000_0010, 32'hCAFE_F00D, 4'hF);
    do_rd(1'b1, e_amo_add, 32'h4000_000C, 32'h5, li0, 5'd4, 0, got);

    // Reset while in AMO_RD
    wait_ready();
    req_i = mk_req(1'b1, 1'b1, e_amo_add, 4'hF, li0, 5'd6, 32'h100, 32'h10);
    req_v_i = 1'b1;
    @(posedge clk); #1;
    req_v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("rst_amo_no_write", mem_v_o, 1'b0);
    @(posedge clk); #1;
    check("rst_amo_state", {resp_v_o, req_ready_o}, 2'b00);
    reset_i = 1'b0;
    #1;
    check("rst_amo_idle", req_ready_o, 1'b1);
    do_rd(1'b0, e_amo_swap, 32'h10, 32'h0, li0, 5'd6, 0, got);
    check("rst_amo_mem_kept", got, 32'hDEAD_BEEF);

    // Random mix
    for (int n = 0; n < 120; n++) begin
      int          kind = $urandom_range(0, 2);
      int          sel  = $urandom_range(0, 9);
      logic [31:0] a    = $urandom_range(0, 15) * 4;
      logic [31:0] d    = $urandom;
      load_info_s  li   = load_info_s'(6'($urandom));
      if (sel == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      else if (sel == 1) a = a | 32'($urandom_range(1, 3));
      if (kind == 0) do_store(a, d, 4'($urandom));
      else do_rd(kind == 2, amo_type_e'($urandom_range(0, 3)), a, d, li, 5'($urandom),
                 $urandom_range(0, 3), got);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final_word_%0d", i), sram[i], model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
